muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file: it consumes the two source-register read values plus destination index, computes over a fixed 34-cycle sequence, and presents the result and destination index for writeback. The core's control logic stalls the PC while `busy` is high and writes `result` to `result_reg` on the `done` cycle.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clock `clock`.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  32  rs1 read data (multiplicand / dividend).
- `operand_b`  in  32  rs2 read data (multiplier / divisor).
- `dest_reg`  in  5  rd index, carried to `result_reg`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  32  final value; held until the next accepted start.
- `result_reg`  out  5  latched `dest_reg`; held with `result`.
- `illegal`  out  1  one-cycle pulse with `done` for an op not compiled in.

## Operation
- FSM: IDLE -> CALC (exactly 32 cycles, 5-bit counter 0..31) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
- IDLE: `start`=1 latches `funct3`, `operand_a`, `operand_b`, `dest_reg`; converts operands to magnitudes per signedness (MULH/DIV/REM: both signed; MULHSU: a signed, b unsigned; others unsigned); records result sign; counter=0; -> CALC.
- CALC multiply: radix-2 shift-add on a 64-bit product register, one multiplier bit per cycle, LSB first.
- CALC divide: restoring division, one quotient bit per cycle, MSB first; 33-bit partial remainder.
- FIX: negate 64-bit product or quotient/remainder when the recorded sign requires it (remainder takes dividend sign); select MUL = product[31:0], MULH* = product[63:32]; apply special cases; load `result`, `result_reg`.
- Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> operand_a. Overflow (DIV, 0x80000000 / 0xFFFFFFFF) -> 0x80000000; REM -> 0. Special cases keep the full fixed latency.
- DONE: `done`=1 for one cycle; -> IDLE unconditionally.
- `start` outside IDLE (including the DONE cycle) is ignored; operand changes after acceptance have no effect.
- Outputs after reset: `busy`=0, `done`=0, `illegal`=0, `result`=0, `result_reg`=0; state IDLE.
- Reset at any point, including mid-CALC, aborts the operation: no `done` is produced and outputs return to reset values on the next edge.

## Timing
- Cycle 0 = cycle with `start`=1 in IDLE. Cycles 1-32 CALC, cycle 33 FIX, cycle 34 DONE (`done`=1, `result` valid). Next start is accepted in cycle 35 at the earliest.
- `busy` is high in cycles 1-34. Registered outputs only; no combinational path from inputs to any output.
- Throughput: one operation per 35 cycles.

## Configuration
- `MULDIV_DIV_EN` defined: full RV32M, divider datapath compiled in; `illegal` is tied 0.
- Not defined: divider logic omitted. Ops with `funct3[2]`=1 still follow the full FSM/latency but yield `result`=0 and pulse `illegal` with `done`. Multiply ops are unchanged.

## Test plan
- MUL 7 x 0xFFFFFFFD -> `result`=0xFFFFFFEB, `done` exactly in cycle 34, `result_reg`=`dest_reg`, `busy` high in cycles 1-34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIV x / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; all in cycle 34.
- `start` pulsed in cycles 5 and 34 with different operands -> ignored, original result returned; reset asserted in cycle 10 -> no `done`, all outputs 0, new start accepted.
- Without `MULDIV_DIV_EN`: DIVU 100 / 7 -> `result`=0, `illegal`=1 and `done`=1 in cycle 34; MUL unaffected.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 CALC cycles, then FIX and DONE, for 34 cycles from start to done.
// Define MULDIV_DIV_EN to compile in the divider; without it, divide ops report illegal with a zero result.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [4:0]      dest_reg_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      result_reg_o,
    output logic            illegal_o
);
    // state  | meaning
    // S_IDLE | waiting for start, result held
    // S_CALC | 32 iterations, one operand bit per cycle
    // S_FIX  | sign fix-up, special cases, result load
    // S_DONE | done pulse
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q;
    logic [4:0]        cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        dest_q;
    logic [4:0]        result_reg_q;
    logic [XLEN-1:0]   a_mag_q;
    logic [XLEN-1:0]   b_mag_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] prod_q;
    logic              neg_q;
    logic              busy_q;
    logic              done_q;

    logic              sign_a;
    logic              sign_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag_d;
    logic [XLEN-1:0]   b_mag_d;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_d;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   result_d;

`ifdef MULDIV_DIV_EN
    logic              a_neg_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [XLEN-1:0]   b_raw_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN+1:0]   div_cat;
    logic              div_ge;
    logic [XLEN:0]     rem_d;
    logic [XLEN-1:0]   quo_d;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
`else
    logic              illegal_q;
`endif

    always_comb begin
        sign_a  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                  (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sign_b  = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        a_neg   = sign_a & operand_a_i[XLEN-1];
        b_neg   = sign_b & operand_b_i[XLEN-1];
        a_mag_d = a_neg ? -operand_a_i : operand_a_i;
        b_mag_d = b_neg ? -operand_b_i : operand_b_i;
    end

    // Multiplier lives in the low half and is consumed LSB first as the sum shifts in from the top.
    always_comb begin
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
        prod_d  = {mul_sum, prod_q[XLEN-1:1]};
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        div_cat = {rem_q, quo_q[XLEN-1]};
        div_ge  = div_cat >= {2'b00, b_mag_q};
        rem_d   = div_ge ? (XLEN+1)'(div_cat - {2'b00, b_mag_q}) : div_cat[XLEN:0];
        quo_d   = {quo_q[XLEN-2:0], div_ge};
    end
`endif

    always_comb begin
        prod_s   = neg_q ? -prod_q : prod_q;
        result_d = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        quo_s = neg_q ? -quo_q : quo_q;
        rem_s = a_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        if (op_q[2]) begin
            if (b_raw_q == '0) begin
                result_d = op_q[1] ? a_raw_q : '1;
            end else if (!op_q[0] && (a_raw_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw_q == '1)) begin
                result_d = op_q[1] ? '0 : a_raw_q;
            end else begin
                result_d = op_q[1] ? rem_s : quo_s;
            end
        end
`else
        if (op_q[2]) begin
            result_d = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            dest_q       <= '0;
            result_reg_q <= '0;
            a_mag_q      <= '0;
            b_mag_q      <= '0;
            result_q     <= '0;
            prod_q       <= '0;
            neg_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MULDIV_DIV_EN
            a_neg_q      <= 1'b0;
            a_raw_q      <= '0;
            b_raw_q      <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
`else
            illegal_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q    <= funct3_i;
                        dest_q  <= dest_reg_i;
                        a_mag_q <= a_mag_d;
                        b_mag_q <= b_mag_d;
                        neg_q   <= a_neg ^ b_neg;
                        prod_q  <= {{XLEN{1'b0}}, b_mag_d};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
`ifdef MULDIV_DIV_EN
                        a_neg_q <= a_neg;
                        a_raw_q <= operand_a_i;
                        b_raw_q <= operand_b_i;
                        quo_q   <= a_mag_d;
                        rem_q   <= '0;
`endif
                    end
                end
                S_CALC: begin
                    prod_q <= prod_d;
`ifdef MULDIV_DIV_EN
                    quo_q  <= quo_d;
                    rem_q  <= rem_d;
`endif
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q     <= result_d;
                    result_reg_q <= dest_q;
                    done_q       <= 1'b1;
`ifndef MULDIV_DIV_EN
                    illegal_q    <= op_q[2];
`endif
                    state_q      <= S_DONE;
                end
                default: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
`ifndef MULDIV_DIV_EN
                    illegal_q <= 1'b0;
`endif
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign result_reg_o = result_reg_q;
`ifdef MULDIV_DIV_EN
    assign illegal_o    = 1'b0;
`else
    assign illegal_o    = illegal_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit; expectations adapt to whether MULDIV_DIV_EN is defined.
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest_reg;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  result_reg;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start_i      (start),
        .funct3_i     (funct3),
        .operand_a_i  (operand_a),
        .operand_b_i  (operand_b),
        .dest_reg_i   (dest_reg),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .result_reg_o (result_reg),
        .illegal_o    (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model straight from the RV32M definitions, using wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub = longint'({32'h0, b});
        longint unsigned pu = {32'h0, a} * {32'h0, b};
        longint          ps;
`ifdef MULDIV_DIV_EN
        int              ia = int'(a);
        int              ib = int'(b);
`endif
        case (f3)
            3'd0: begin ps = sa * sb; return ps[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * ub; return ps[63:32]; end
            3'd3: return pu[63:32];
`ifdef MULDIV_DIV_EN
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op and observes the bus for cycles 1..last_k; start is re-pulsed with junk at p1/p2.
    task automatic exec_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int p1, input int p2, input int last_k,
                           output logic [31:0] res, output logic [4:0] rr, output logic ill,
                           output int done_cyc, output int done_cnt, output bit busy_ok,
                           output logic [31:0] res_hold);
        res      = 'x;
        rr       = 'x;
        ill      = 'x;
        res_hold = 'x;
        done_cyc = -1;
        done_cnt = 0;
        busy_ok  = 1'b1;
        @(negedge clock);
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        dest_reg  = rd;
        @(posedge clock);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    res      = result;
                    rr       = result_reg;
                    ill      = illegal;
                end
            end
            if (busy !== 1'(k <= 34)) busy_ok = 1'b0;
            if (k == last_k) res_hold = result;
            start     = (k == p1) || (k == p2);
            funct3    = 3'($urandom);
            operand_a = $urandom;
            operand_b = $urandom;
            dest_reg  = 5'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        funct3    = 3'd0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        dest_reg  = 5'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++; if (result_reg !== 5'h0) begin n_fail++; $display("FAIL reset_result_reg: got %h expected 0", result_reg); end
        reset = 1'b0;
    endtask

    task automatic test_mul_directed();
        logic [2:0]  fv [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] av [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] ev [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res, hold;
        logic [4:0]  rr;
        logic        ill;
        int          dc, dn;
        bit          bok;
        for (int i = 0; i < 4; i++) begin
            exec_op(fv[i], av[i], bv[i], 5'(i + 3), 0, 0, 36, res, rr, ill, dc, dn, bok, hold);
            n_checks++; if (res !== ev[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, ev[i]); end
            n_checks++; if (rr !== 5'(i + 3)) begin n_fail++; $display("FAIL mul_result_reg[%0d]: got %0d expected %0d", i, rr, i + 3); end
            n_checks++; if (dc !== 34 || dn !== 1) begin n_fail++; $display("FAIL mul_done_timing[%0d]: got cycle %0d count %0d expected cycle 34 count 1", i, dc, dn); end
            n_checks++; if (!bok) begin n_fail++; $display("FAIL mul_busy_window[%0d]: busy not high exactly in cycles 1-34", i); end
            n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL mul_illegal[%0d]: got %b expected 0", i, ill); end
            n_checks++; if (hold !== ev[i]) begin n_fail++; $display("FAIL mul_hold[%0d]: got %h expected %h", i, hold, ev[i]); end
        end
    endtask

    task automatic test_div_directed();
        logic [2:0]  fv [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] av [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd1234, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res, hold, exp;
        logic [4:0]  rr;
        logic        ill;
        int          dc, dn;
        bit          bok;
        for (int i = 0; i < 8; i++) begin
            exp = DIV_EN ? ev[i] : 32'h0;
            exec_op(fv[i], av[i], bv[i], 5'(20 + i), 0, 0, 36, res, rr, ill, dc, dn, bok, hold);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp); end
            n_checks++; if (ill !== !DIV_EN) begin n_fail++; $display("FAIL div_illegal[%0d]: got %b expected %b", i, ill, !DIV_EN); end
            n_checks++; if (dc !== 34 || dn !== 1) begin n_fail++; $display("FAIL div_done_timing[%0d]: got cycle %0d count %0d expected cycle 34 count 1", i, dc, dn); end
            n_checks++; if (!bok) begin n_fail++; $display("FAIL div_busy_window[%0d]: busy not high exactly in cycles 1-34", i); end
            n_checks++; if (rr !== 5'(20 + i)) begin n_fail++; $display("FAIL div_result_reg[%0d]: got %0d expected %0d", i, rr, 20 + i); end
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] res, hold, exp;
        logic [4:0]  rr;
        logic        ill;
        int          dc, dn;
        bit          bok;
        exp = ref_result(3'd0, 32'd123457, 32'd99991);
        exec_op(3'd0, 32'd123457, 32'd99991, 5'd9, 5, 34, 36, res, rr, ill, dc, dn, bok, hold);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL ignored_start_result: got %h expected %h", res, exp); end
        n_checks++; if (dc !== 34 || dn !== 1) begin n_fail++; $display("FAIL ignored_start_done: got cycle %0d count %0d expected cycle 34 count 1", dc, dn); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL ignored_start_busy: busy not low after cycle 34"); end
        n_checks++; if (hold !== exp) begin n_fail++; $display("FAIL ignored_start_hold: got %h expected %h", hold, exp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, hold, exp;
        logic [4:0]  rr;
        logic        ill;
        int          dc, dn, seen;
        bit          bok;
        exec_op(3'd0, 32'd3, 32'd5, 5'd17, 0, 0, 36, res, rr, ill, dc, dn, bok, hold);
        n_checks++; if (res !== 32'd15) begin n_fail++; $display("FAIL pre_reset_result: got %h expected %h", res, 32'd15); end
        @(negedge clock);
        start     = 1'b1;
        funct3    = 3'd1;
        operand_a = 32'h1234_5678;
        operand_b = 32'h9ABC_DEF0;
        dest_reg  = 5'd30;
        @(posedge clock);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 10) reset = 1'b1;
        end
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset_flags: got busy %b done %b illegal %b expected 0 0 0", busy, done, illegal); end
        n_checks++; if (result !== 32'h0 || result_reg !== 5'h0)
            begin n_fail++; $display("FAIL mid_reset_result: got %h/%0d expected 0/0", result, result_reg); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", seen); end
        exp = ref_result(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        exec_op(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd4, 0, 0, 36, res, rr, ill, dc, dn, bok, hold);
        n_checks++; if (res !== exp || rr !== 5'd4 || dc !== 34)
            begin n_fail++; $display("FAIL post_reset_op: got %h rd %0d cycle %0d expected %h rd 4 cycle 34", res, rr, dc, exp); end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, hold, exp;
        logic [4:0]  rd, rr;
        logic        ill, exp_ill;
        int          dc, dn;
        bit          bok;
        for (int i = 0; i < 40; i++) begin
            f3      = 3'($urandom);
            a       = rand_operand();
            b       = rand_operand();
            rd      = 5'($urandom);
            exp     = ref_result(f3, a, b);
            exp_ill = f3[2] && !DIV_EN;
            exec_op(f3, a, b, rd, 0, 0, 35, res, rr, ill, dc, dn, bok, hold);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL rand_result[%0d] op %0d a %h b %h: got %h expected %h", i, f3, a, b, res, exp); end
            n_checks++; if (rr !== rd || ill !== exp_ill) begin n_fail++; $display("FAIL rand_tags[%0d]: got rd %0d illegal %b expected rd %0d illegal %b", i, rr, ill, rd, exp_ill); end
            n_checks++; if (dc !== 34 || dn !== 1 || !bok) begin n_fail++; $display("FAIL rand_timing[%0d]: got cycle %0d count %0d busy_ok %b", i, dc, dn, bok); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  fv [3] = '{3'd1, 3'd0, 3'd5};
        logic [31:0] av [3] = '{32'hFFFF_FFFE, 32'd65535, 32'd1000};
        logic [31:0] bv [3] = '{32'd3, 32'd65537, 32'd33};
        logic [31:0] res, hold, exp;
        logic [4:0]  rr;
        logic        ill;
        int          dc, dn;
        bit          bok;
        for (int i = 0; i < 3; i++) begin
            exp = ref_result(fv[i], av[i], bv[i]);
            exec_op(fv[i], av[i], bv[i], 5'(10 + i), 0, 0, 34, res, rr, ill, dc, dn, bok, hold);
            n_checks++; if (res !== exp || rr !== 5'(10 + i) || dc !== 34 || !bok)
                begin n_fail++; $display("FAIL b2b[%0d]: got %h rd %0d cycle %0d busy_ok %b expected %h rd %0d cycle 34", i, res, rr, dc, bok, exp, 10 + i); end
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
